// File: rtl/mcu_fpga_bus_pkg.sv
// Shared definitions for the 8-bit MCU<->FPGA register bus (initiator and responder).
package mcu_fpga_bus_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 8;
  localparam int PIN_REGS = 16;

  // Output pin-state bytes (MCU-written) occupy the low half of the map,
  // input pin-state bytes (read-only from the MCU side) the high half.
  localparam logic [ADDR_W-1:0] OUT_REG_BASE = 5'h00;
  localparam logic [ADDR_W-1:0] IN_REG_BASE  = 5'h10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE,
    ST_DONE
  } bus_init_state_t;

endpackage

// File: rtl/ack_sync2.sv
// Two-flop synchroniser for a single asynchronous handshake bit.
module ack_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // next values: shift the input through the two stages
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  // synchroniser flops, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/mcu_bus_initiator.sv
// MCU-side bus initiator: single read/write commands sequenced as setup,
// strobe, ack handshake and release, with a per-phase ack timeout.
module mcu_bus_initiator #(
  parameter int ADDR_W         = mcu_fpga_bus_pkg::ADDR_W,
  parameter int DATA_W         = mcu_fpga_bus_pkg::DATA_W,
  parameter int SETUP_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              CLK50,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic              bus_mstr,
  output logic [DATA_W-1:0] bus_data_o,
  output logic              bus_data_oe,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_ack
);

  import mcu_fpga_bus_pkg::*;

  localparam int SET_W = 4;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SET_W-1:0] SETUP_LAST = SET_W'(SETUP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  bus_init_state_t   state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              timeout_q, timeout_d;
  logic [SET_W-1:0]  setup_cnt_q, setup_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              ack_s;
  logic              tmo_hit;

  ack_sync2 u_ack_sync (
    .clk   (CLK50),
    .rst_n (RST_N),
    .d     (bus_ack),
    .q     (ack_s)
  );

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  // state register
  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next-state: a stale ack holds SETUP; each ack wait is bounded by the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_valid) state_d = ST_SETUP;
      ST_SETUP: begin
        if (ack_s) begin
          if (tmo_hit) state_d = ST_DONE;
        end else if (setup_cnt_q == SETUP_LAST) begin
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (ack_s)        state_d = ST_RELEASE;
        else if (tmo_hit) state_d = ST_DONE;
      end
      ST_RELEASE: if (!ack_s || tmo_hit) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // command/response datapath next values
  always_comb begin
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    timeout_d   = timeout_q;
    setup_cnt_d = setup_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d      = req_addr;
          write_d     = req_write;
          wdata_d     = req_write ? req_wdata : '0;
          rdata_d     = '0;
          timeout_d   = 1'b0;
          setup_cnt_d = '0;
          tmo_cnt_d   = '0;
        end
      end
      ST_SETUP: begin
        // setup count is frozen while a stale ack is still high
        if (ack_s) begin
          if (tmo_hit) timeout_d = 1'b1;
          else         tmo_cnt_d = tmo_cnt_q + 1'b1;
        end else begin
          setup_cnt_d = setup_cnt_q + 1'b1;
          tmo_cnt_d   = '0;
        end
      end
      ST_STROBE: begin
        if (ack_s) begin
          if (!write_q) rdata_d = bus_data_i;
          tmo_cnt_d = '0;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          rdata_d   = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (ack_s) begin
          if (tmo_hit) begin
            timeout_d = 1'b1;
            rdata_d   = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      timeout_q   <= 1'b0;
      setup_cnt_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      timeout_q   <= timeout_d;
      setup_cnt_q <= setup_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  // outputs decoded from state only, so reset drops the strobes at once
  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    bus_mstr    = 1'b0;
    bus_we      = 1'b0;
    bus_data_oe = 1'b0;
    case (state_q)
      ST_IDLE:    req_ready = 1'b1;
      ST_SETUP:   bus_data_oe = write_q;
      ST_STROBE: begin
        bus_mstr    = 1'b1;
        bus_we      = write_q;
        bus_data_oe = write_q;
      end
      ST_RELEASE: bus_data_oe = write_q;
      ST_DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_rdata   = rdata_q;
  assign rsp_timeout = timeout_q & (state_q == ST_DONE);
  assign bus_addr    = addr_q;
  assign bus_data_o  = wdata_q;

endmodule

// File: tb/tb_mcu_bus_initiator.sv
// Bench for mcu_bus_initiator: responder model on the bus side, table-driven
// commands, hand-written corner sequences and a randomized command stream.
module tb_mcu_bus_initiator;

  import mcu_fpga_bus_pkg::*;

  localparam int S = 2;
  localparam int T = 8;

  logic       CLK50 = 1'b0;
  logic       RST_N;
  logic       req_valid, req_ready, req_write;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic [4:0] bus_addr;
  logic       bus_we, bus_mstr, bus_data_oe;
  logic [7:0] bus_data_o;
  logic [7:0] bus_data_i;
  logic       bus_ack;

  int errors = 0;
  int checks = 0;

  // responder controls and state
  int   resp_rise  = 0;
  int   resp_fall  = 0;
  bit   resp_noack = 0;
  bit   resp_stuck = 0;
  int   rcnt = 0;
  logic [7:0] resp_mem [32];
  logic [7:0] exp_mem  [32];

  bit busy = 0;
  bit cur_write = 0;

  mcu_bus_initiator #(
    .ADDR_W         (5),
    .DATA_W         (8),
    .SETUP_CYCLES   (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .CLK50       (CLK50),
    .RST_N       (RST_N),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .bus_addr    (bus_addr),
    .bus_we      (bus_we),
    .bus_mstr    (bus_mstr),
    .bus_data_o  (bus_data_o),
    .bus_data_oe (bus_data_oe),
    .bus_data_i  (bus_data_i),
    .bus_ack     (bus_ack)
  );

  always #5 CLK50 = ~CLK50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responder: acks resp_rise negedges after seeing the strobe, releases
  // resp_fall negedges after the strobe drops; can refuse or stick the ack.
  always @(negedge CLK50) begin
    if (!RST_N) begin
      bus_ack = 1'b0;
      rcnt    = 0;
    end else if (!bus_ack) begin
      if (bus_mstr && !resp_noack) begin
        if (rcnt >= resp_rise) begin
          bus_ack = 1'b1;
          rcnt    = 0;
          if (bus_we) begin
            if (bus_addr < 5'h10) resp_mem[bus_addr] = bus_data_o;
          end else begin
            bus_data_i = resp_mem[bus_addr];
          end
        end else begin
          rcnt++;
        end
      end else begin
        rcnt       = 0;
        bus_data_i = 8'($urandom);
      end
    end else if (!bus_mstr && !resp_stuck) begin
      if (rcnt >= resp_fall) begin
        bus_ack = 1'b0;
        rcnt    = 0;
      end else begin
        rcnt++;
      end
    end
  end

  // data must never be driven onto the bus during a read
  always @(negedge CLK50) begin
    if (RST_N && busy && !cur_write) check("oe_on_read", 32'(bus_data_oe), 0);
  end

  // Reference latency, accept edge to rsp_valid: setup + ack-rise + ack-fall + 1.
  // Ack-rise = responder delay + half-cycle launch + 2 sync flops;
  // ack-fall = responder delay + 2 sync flops.
  function automatic int model_latency(input int rise, input int fall);
    return S + (rise + 3) + (fall + 2) + 1;
  endfunction

  task automatic run_cmd(input string nm, input logic wr, input logic [4:0] a,
                         input logic [7:0] wd, input int rd, input int fd,
                         input logic [7:0] exp_rd, input logic exp_to,
                         input int exp_lat, output int mstr_n);
    int n;
    int lat;
    int bad;
    resp_rise = rd;
    resp_fall = fd;
    @(negedge CLK50);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge CLK50);
      n++;
    end
    check({nm, "/accept"}, 32'(req_ready), 1);
    @(negedge CLK50);
    req_valid = 1'b0;
    req_addr  = 5'($urandom);
    req_wdata = 8'($urandom);
    cur_write = wr;
    busy      = 1'b1;
    check({nm, "/setup_addr"}, 32'(bus_addr), 32'(a));
    check({nm, "/setup_oe"}, 32'(bus_data_oe), 32'(wr));
    check({nm, "/setup_mstr"}, 32'(bus_mstr), 0);
    if (wr) check({nm, "/setup_data"}, 32'(bus_data_o), 32'(wd));
    lat    = 0;
    bad    = 0;
    mstr_n = 0;
    while (!rsp_valid && lat < 300) begin
      if (bus_mstr) begin
        mstr_n++;
        if (bus_we !== wr || bus_addr !== a) bad++;
      end
      @(negedge CLK50);
      lat++;
    end
    check({nm, "/rsp_valid"}, 32'(rsp_valid), 1);
    check({nm, "/rsp_timeout"}, 32'(rsp_timeout), 32'(exp_to));
    check({nm, "/rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
    check({nm, "/done_mstr_oe"}, {30'd0, bus_mstr, bus_data_oe}, 0);
    check({nm, "/strobe_we_addr"}, 32'(bad), 0);
    if (!exp_to) check({nm, "/mstr_cycles"}, 32'(mstr_n), 32'(rd + 3));
    if (exp_lat >= 0) check({nm, "/latency"}, 32'(lat), 32'(exp_lat));
    @(negedge CLK50);
    check({nm, "/rsp_one_cycle"}, 32'(rsp_valid), 0);
    check({nm, "/ready_after"}, 32'(req_ready), 1);
    busy = 1'b0;
  endtask

  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic [7:0] wdata;
    int         rise;
    int         fall;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int mn;
    int n;
    int rv;
    int early;
    logic       wr;
    logic [4:0] a;
    logic [7:0] wd;
    int rd, fd;

    vecs[0] = '{1'b1, 5'h01, 8'hAA, 3, 1, 8'h00};
    vecs[1] = '{1'b0, 5'h03, 8'h00, 0, 2, 8'h5C};
    vecs[2] = '{1'b0, 5'h01, 8'h00, 1, 0, 8'hAA};
    vecs[3] = '{1'b1, 5'h1F, 8'h77, 2, 0, 8'h00};
    vecs[4] = '{1'b0, 5'h1F, 8'h00, 0, 0, 8'hAF};
    vecs[5] = '{1'b0, 5'h10, 8'h00, 2, 3, 8'hA0};
    vecs[6] = '{1'b1, 5'h0F, 8'hFF, 1, 1, 8'h00};
    vecs[7] = '{1'b0, 5'h0F, 8'h00, 0, 1, 8'hFF};

    for (int i = 0; i < 32; i++) begin
      resp_mem[i] = (i < PIN_REGS) ? 8'h00 : 8'(8'hA0 + i - 16);
      exp_mem[i]  = (i < 16) ? 8'h00 : 8'(160 + i - 16);
    end
    resp_mem[3] = 8'h5C;
    exp_mem[3]  = 8'h5C;

    RST_N      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    bus_ack    = 1'b0;
    bus_data_i = '0;
    repeat (3) @(negedge CLK50);

    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 0);
    check("rst_bus_addr", 32'(bus_addr), 0);
    check("rst_bus_we", 32'(bus_we), 0);
    check("rst_bus_mstr", 32'(bus_mstr), 0);
    check("rst_bus_data_o", 32'(bus_data_o), 0);
    check("rst_bus_data_oe", 32'(bus_data_oe), 0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK50);

    // table-driven commands
    for (int i = 0; i < 8; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].rise, vecs[i].fall, vecs[i].exp_rdata, 1'b0,
              model_latency(vecs[i].rise, vecs[i].fall), mn);
      if (vecs[i].wr && vecs[i].addr < 5'h10) exp_mem[vecs[i].addr] = vecs[i].wdata;
      if (i == 0) check("resp_reg1", 32'(resp_mem[1]), 32'h0AA);
    end

    // back-to-back with req_valid held: second command only after rsp_valid
    resp_rise = 1;
    resp_fall = 1;
    @(negedge CLK50);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 5'h02;
    req_wdata = 8'h11;
    busy      = 1'b1;
    cur_write = 1'b1;
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge CLK50);
      n++;
    end
    check("b2b_rsp1", 32'(rsp_valid), 1);
    check("b2b_rsp1_timeout", 32'(rsp_timeout), 0);
    check("b2b_ready_at_rsp", 32'(req_ready), 0);
    req_write = 1'b0;
    @(negedge CLK50);
    check("b2b_ready_after_rsp", 32'(req_ready), 1);
    @(negedge CLK50);
    check("b2b_accepted", 32'(req_ready), 0);
    req_valid = 1'b0;
    cur_write = 1'b0;
    exp_mem[2] = 8'h11;
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge CLK50);
      n++;
    end
    check("b2b_rsp2", 32'(rsp_valid), 1);
    check("b2b_rdata", 32'(rsp_rdata), 32'h11);
    check("b2b_rsp2_timeout", 32'(rsp_timeout), 0);
    @(negedge CLK50);
    busy = 1'b0;

    // no ack at all: strobe held for T cycles then aborted
    resp_noack = 1'b1;
    run_cmd("noack_wr", 1'b1, 5'h04, 8'h33, 0, 0, 8'h00, 1'b1, S + T, mn);
    check("noack_mstr_cycles", 32'(mn), 32'(T));
    resp_noack = 1'b0;

    // ack stuck high: RELEASE times out, read data discarded
    resp_stuck = 1'b1;
    run_cmd("stuck_rd", 1'b0, 5'h03, 8'h00, 1, 0, 8'h00, 1'b1, S + 1 + 3 + T, mn);

    // next command sees a stale ack and must not strobe until it falls
    fork
      run_cmd("stale_rd", 1'b0, 5'h01, 8'h00, 0, 0, exp_mem[1], 1'b0, -1, mn);
      begin
        early = 0;
        repeat (4) begin
          @(negedge CLK50);
          if (bus_mstr) early++;
        end
        check("stale_no_strobe", 32'(early), 0);
        resp_stuck = 1'b0;
      end
    join

    // reset pulse in the middle of a write strobe
    resp_noack = 1'b1;
    @(negedge CLK50);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 5'h06;
    req_wdata = 8'h55;
    @(negedge CLK50);
    req_valid = 1'b0;
    n = 0;
    while (!bus_mstr && n < 50) begin
      @(negedge CLK50);
      n++;
    end
    check("rst_pre_mstr", 32'(bus_mstr), 1);
    check("rst_pre_we", 32'(bus_we), 1);
    check("rst_pre_oe", 32'(bus_data_oe), 1);
    #2 RST_N = 1'b0;
    #1;
    check("rst_mid_mstr", 32'(bus_mstr), 0);
    check("rst_mid_we", 32'(bus_we), 0);
    check("rst_mid_oe", 32'(bus_data_oe), 0);
    rv = 0;
    repeat (3) begin
      @(negedge CLK50);
      if (rsp_valid) rv++;
    end
    RST_N = 1'b1;
    repeat (10) begin
      @(negedge CLK50);
      if (rsp_valid) rv++;
    end
    check("rst_no_rsp", 32'(rv), 0);
    check("rst_ready", 32'(req_ready), 1);
    resp_noack = 1'b0;

    // randomized command stream against the register-map model
    for (int k = 0; k < 40; k++) begin
      wr = 1'($urandom);
      a  = 5'($urandom);
      wd = 8'($urandom);
      rd = int'($urandom_range(0, 3));
      fd = int'($urandom_range(0, 3));
      run_cmd($sformatf("rnd%0d", k), wr, a, wd, rd, fd,
              wr ? 8'h00 : exp_mem[a], 1'b0, model_latency(rd, fd), mn);
      if (wr && a < 5'h10) exp_mem[a] = wd;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
